// File: rtl/ram32x3_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous 32x3 RAM.
// Define RAM32X3_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module ram32x3_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACC, RD} state_t;

    state_t state;
    logic   winner;
    logic   pick1;

`ifdef RAM32X3_ARBITER_FIXED_PRIO_EN
    always_comb begin
        pick1 = ~req0;
    end
`else
    logic last;

    // Last-winner pointer; resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (state == IDLE && (req0 || req1)) begin
            last <= pick1;
        end
    end

    always_comb begin
        if (req0 && req1) begin
            pick1 = ~last;
        end else begin
            pick1 = req1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            winner   <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            busy     <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            ram_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        winner   <= pick1;
                        ram_addr <= pick1 ? addr1 : addr0;
                        ram_din  <= pick1 ? wdata1 : wdata0;
                        ram_we   <= pick1 ? we1 : we0;
                        gnt0     <= ~pick1;
                        gnt1     <= pick1;
                        busy     <= 1'b1;
                        state    <= ACC;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ACC: begin
                    // ram_we still carries this access's direction during ACC.
                    if (ram_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rvalid0 <= ~winner;
                        rvalid1 <= winner;
                        busy    <= 1'b1;
                        state   <= RD;
                    end
                end
                RD: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The RAM output lands in the RD cycle, so read data is forwarded, not registered.
    always_comb begin
        if (rvalid0 || rvalid1) begin
            rdata = ram_dout;
        end else begin
            rdata = '0;
        end
    end

endmodule
